// File: rtl/seg_blink_scan.sv
// Eight-digit multiplexed hex display scanner with per-digit blink masking.
// Loads land in a shadow buffer and are applied only at the 7->0 digit
// wrap, so a frame never shows a mix of old and new content. Each digit
// dwell begins with a short dead time that blanks the anodes. This avoids
// ghosting between neighbouring digits.
module seg_blink_scan #(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blink,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  mask_in,
  output logic        pending,
  output logic        frame_start,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n
);

  localparam logic [SCAN_BITS-1:0] DEAD_CYCLES = SCAN_BITS'(4);

  // State registers and their next-state values
  logic [SCAN_BITS-1:0] p_q, p_d;
  logic [2:0]           d_q, d_d;
  logic                 blink_q;
  logic [31:0]          shadow_data_q, shadow_data_d;
  logic [7:0]           shadow_mask_q, shadow_mask_d;
  logic [31:0]          active_data_q, active_data_d;
  logic [7:0]           active_mask_q, active_mask_d;
  logic                 pending_q, pending_d;
  logic                 frame_start_q, frame_start_d;
  logic [7:0]           an_n_q, an_n_d;
  logic [6:0]           seg_n_q, seg_n_d;

  // Decode helpers
  logic       p_max;
  logic       wrap;
  logic       swap;
  logic       blank;
  logic [3:0] nibble;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-state logic: scan counters, shadow/active buffers, display outputs
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is inferred.
    p_max  = &p_q;
    wrap   = p_max && (d_q == 3'd7);
    swap   = wrap && pending_q;
    nibble = active_data_q[{d_q, 2'b00} +: 4];
    blank  = (p_q < DEAD_CYCLES) || (active_mask_q[d_q] && !blink_q);

    p_d = p_q + 1'b1;
    d_d = p_max ? d_q + 3'd1 : d_q;

    // Swap takes the pre-edge shadow; a coincident load refills the shadow
    // and keeps pending set so it is applied at the following wrap.
    active_data_d = swap ? shadow_data_q : active_data_q;
    active_mask_d = swap ? shadow_mask_q : active_mask_q;
    shadow_data_d = load ? data_in : shadow_data_q;
    shadow_mask_d = load ? mask_in : shadow_mask_q;
    pending_d     = load || (pending_q && !swap);

    frame_start_d = wrap;
    an_n_d        = blank ? 8'hFF : ~(8'b1 << d_q);
    seg_n_d       = blank ? 7'h7F : hex_to_seg(nibble);
  end

  // Register all state with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      p_q           <= '0;
      d_q           <= '0;
      blink_q       <= 1'b0;
      shadow_data_q <= '0;
      shadow_mask_q <= '0;
      active_data_q <= '0;
      active_mask_q <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_n_q        <= 8'hFF;
      seg_n_q       <= 7'h7F;
    end else begin
      p_q           <= p_d;
      d_q           <= d_d;
      blink_q       <= blink;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      active_data_q <= active_data_d;
      active_mask_q <= active_mask_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;

endmodule

// File: tb/tb_seg_blink_scan.sv
// Directed bench for seg_blink_scan with SCAN_BITS = 4 (16-cycle dwell,
// 128-cycle frame). A time-based reference model predicts every output
// each cycle. Literal expectations at key points pin that model.
module tb_seg_blink_scan;

  localparam int SB    = 4;
  localparam int DWELL = 1 << SB;
  localparam int FRAME = 8 * DWELL;

  logic        clk = 1'b0;
  logic        reset;
  logic        blink;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  mask_in;
  logic        pending;
  logic        frame_start;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;

  int errors = 0;
  int checks = 0;

  seg_blink_scan #(.SCAN_BITS(SB)) dut (
    .clk         (clk),
    .reset       (reset),
    .blink       (blink),
    .load        (load),
    .data_in     (data_in),
    .mask_in     (mask_in),
    .pending     (pending),
    .frame_start (frame_start),
    .an_n        (an_n),
    .seg_n       (seg_n)
  );

  always #5 clk = ~clk;

  // Segment patterns for hex digits 0..F, {g,f,e,d,c,b,a}, active low
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position derived from elapsed cycles since reset
  int          t;
  logic        blink_prev;
  logic [31:0] m_sh_data, m_ac_data;
  logic [7:0]  m_sh_mask, m_ac_mask;
  logic        m_pend;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_fs, exp_pend;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    int pos, dig;
    logic is_wrap;
    if (reset) begin
      t = 0; blink_prev = 1'b0;
      m_sh_data = '0; m_sh_mask = '0; m_ac_data = '0; m_ac_mask = '0; m_pend = 1'b0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_fs = 1'b0; exp_pend = 1'b0;
      model_valid = 1'b1;
    end else begin
      pos     = t % DWELL;
      dig     = (t / DWELL) % 8;
      is_wrap = (t % FRAME) == FRAME - 1;
      if (pos < 4 || (m_ac_mask[dig] && !blink_prev)) begin
        exp_an = 8'hFF; exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(8'd1 << dig);
        exp_seg = seg_tab[m_ac_data[dig*4 +: 4]];
      end
      exp_fs = is_wrap;
      if (is_wrap && m_pend) begin
        m_ac_data = m_sh_data; m_ac_mask = m_sh_mask; m_pend = 1'b0;
      end
      if (load) begin
        m_sh_data = data_in; m_sh_mask = mask_in; m_pend = 1'b1;
      end
      exp_pend   = m_pend;
      blink_prev = blink;
      t++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_an_n", an_n, exp_an);
      check("cyc_seg_n", seg_n, exp_seg);
      check("cyc_frame_start", frame_start, exp_fs);
      check("cyc_pending", pending, exp_pend);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] m);
    data_in = d; mask_in = m; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // Advance until frame_start is seen, bounded to a little over two frames
  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 40; i++) begin
      step(1);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("frame_start_seen", found, 1'b1);
  endtask

  initial begin
    reset = 1'b1; blink = 1'b1; load = 1'b0; data_in = '0; mask_in = '0;
    step(3);
    check("reset_an", an_n, 8'hFF);
    check("reset_seg", seg_n, 7'h7F);
    check("reset_pending", pending, 1'b0);
    reset = 1'b0;

    // Dead time then digit 0 of all-zero frame, then digit 1
    step(4);
    check("dead_an", an_n, 8'hFF);
    step(1);
    check("d0_an", an_n, 8'hFE);
    check("d0_seg", seg_n, 7'b1000000);
    step(16);
    check("d1_an", an_n, 8'hFD);

    // Mid-frame load is held until the wrap
    do_load(32'hFEDCBA98, 8'h00);
    check("load_pending", pending, 1'b1);
    wait_frame();
    check("swap_pending_clr", pending, 1'b0);
    step(5);
    check("new_d0_an", an_n, 8'hFE);
    check("new_d0_seg", seg_n, 7'b0000000);
    step(112);
    check("new_d7_an", an_n, 8'h7F);
    check("new_d7_seg", seg_n, 7'b0001110);

    // Blink mask on digit 2: two-cycle latency, digit 3 unaffected
    do_load(32'hFEDCBA98, 8'h04);
    wait_frame();
    step(39);
    check("d2_visible_an", an_n, 8'hFB);
    check("d2_visible_seg", seg_n, 7'b0001000);
    blink = 1'b0;
    step(1);
    check("blink_lat1_an", an_n, 8'hFB);
    step(1);
    check("blink_dark_an", an_n, 8'hFF);
    check("blink_dark_seg", seg_n, 7'h7F);
    step(16);
    check("d3_dark_an", an_n, 8'hF7);
    check("d3_dark_seg", seg_n, 7'b0000011);
    blink = 1'b1;

    // Load on the exact wrap edge while pending
    wait_frame();
    step(10);
    do_load(32'h33333333, 8'h00);
    step(116);
    do_load(32'h44444444, 8'h00);
    check("wrap_load_fs", frame_start, 1'b1);
    check("wrap_load_pending", pending, 1'b1);
    step(5);
    check("wrap_old_seg", seg_n, 7'b0110000);
    wait_frame();
    check("wrap_next_pending", pending, 1'b0);
    step(5);
    check("wrap_new_seg", seg_n, 7'b0011001);

    // Two loads in one frame: only the latest is shown
    do_load(32'h11111111, 8'h00);
    step(3);
    do_load(32'h22222222, 8'h00);
    wait_frame();
    step(5);
    check("latest_an", an_n, 8'hFE);
    check("latest_seg", seg_n, 7'b0100100);

    // Reset at digit 5 with pending data discards the shadow
    step(16);
    do_load(32'h55555555, 8'hFF);
    check("pre_rst_pending", pending, 1'b1);
    step(64);
    check("d5_an", an_n, 8'hDF);
    check("d5_seg", seg_n, 7'b0100100);
    reset = 1'b1;
    step(1);
    check("rst_an", an_n, 8'hFF);
    check("rst_seg", seg_n, 7'h7F);
    check("rst_fs", frame_start, 1'b0);
    check("rst_pending", pending, 1'b0);
    reset = 1'b0;
    step(5);
    check("post_rst_an", an_n, 8'hFE);
    check("post_rst_seg", seg_n, 7'b1000000);
    wait_frame();
    step(5);
    check("post_rst_frame_seg", seg_n, 7'b1000000);
    check("post_rst_frame_an", an_n, 8'hFE);

    step(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_blink_scan.md
SEG_BLINK_SCAN -- requirements
Module: seg_blink_scan

Interface
REQ-001 Parameter SCAN_BITS, default 16, prescaler width; digit dwell = 2^SCAN_BITS clk cycles; legal range 3..20.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; clock is clk.
REQ-004 blink  input  1  blink-phase level from the upstream blink generator; 1 = visible phase, 0 = dark phase.
REQ-005 load  input  1  single-cycle request to capture data_in and mask_in.
REQ-006 data_in  input  32  eight hex nibbles; bits [4d+3:4d] = digit d.
REQ-007 mask_in  input  8  per-digit blink enable; bit d = 1 blanks digit d during dark phase.
REQ-008 pending  output  1  shadow holds data not yet applied to the display.
REQ-009 frame_start  output  1  one-cycle pulse when scanning restarts at digit 0.
REQ-010 an_n  output  8  active-low digit anodes, registered.
REQ-011 seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered.

Function
REQ-012 Prescaler p counts 0..2^SCAN_BITS-1, +1 per cycle, wraps to 0.
REQ-013 Digit index d (3 bits) increments on the edge where p = max; 7 wraps to 0.
REQ-014 blink sampled into flop blink_q every cycle; outputs use blink_q only.
REQ-015 Dead time: an_n = 8'hFF while p < 4 (registered value, i.e. the first 4 output cycles of each dwell).
REQ-016 Otherwise an_n = ~(8'b1 << d), except an_n = 8'hFF when active_mask[d] = 1 and blink_q = 0.
REQ-017 seg_n = hex decode of active_data nibble d, registered; blanked digits drive seg_n = 7'h7F.
REQ-018 Decode: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-019 Latency: a blink change reaches an_n/seg_n 2 cycles later (sync flop + output register).
REQ-020 load = 1: shadow_data <= data_in, shadow_mask <= mask_in, pending <= 1.
REQ-021 Frame swap: on the edge where d wraps 7->0 and pending = 1 (pre-edge), active_data/active_mask <= shadow contents (pre-edge), pending <= 0.
REQ-022 load on the swap edge: swap uses old shadow; new data overwrites shadow; pending stays 1; applied at next wrap.
REQ-023 load while pending = 1 and no swap: shadow overwritten; only the latest load is displayed.
REQ-024 Active registers change only at frame swap; no digit ever shows mixed old/new content within a frame.
REQ-025 frame_start = 1 for exactly the cycle after the 7->0 wrap edge, whether or not a swap occurred.
REQ-026 No backpressure on load; load is accepted every cycle it is asserted.

Reset
REQ-027 reset = 1: p = 0, d = 0, blink_q = 0, shadow/active data = 0, shadow/active mask = 0, pending = 0.
REQ-028 reset = 1: an_n = 8'hFF, seg_n = 7'h7F, frame_start = 0 on the next edge.
REQ-029 reset mid-frame or with pending = 1 discards shadow contents; scanning resumes from d = 0, p = 0.
REQ-030 First frame after reset displays "00000000" (mask 0) after dead time.

Verification (SCAN_BITS = 4)
REQ-031 Reset release, blink = 1 -> an_n = FF cycles 0-4, then FE with seg_n = 1000000; an_n FD at dwell 2.
REQ-032 load data_in = 32'hFEDCBA98 mid-frame -> pending = 1; old digits until wrap; frame_start pulse; pending = 0; digit 0 shows 0000000 (8), digit 7 shows 0001110 (F).
REQ-033 mask_in = 8'h04, blink toggles 1->0 while d = 2 -> 2 cycles later an_n = FF, seg_n = 7F; other digits unaffected.
REQ-034 load on exact 7->0 wrap edge with pending = 1 -> old shadow displayed; pending stays 1; new data shown after next frame_start.
REQ-035 Two loads in one frame (11111111 then 22222222) -> only 2s displayed after wrap.
REQ-036 reset asserted at d = 5 with pending = 1 -> all REQ-027/028 values next edge; display shows zeros, not shadow data.
